// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - 8N1 UART transmitter that drains a synchronous FIFO read port
// One pop per frame; the popped byte is latched one cycle later, when the FIFO output is valid.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data_in,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic [BAUD_W-1:0] r_baud;
    logic              r_tx;
    logic              r_byte_done;
    logic              w_pop;
    logic              w_wrap;

    // Gated by reset so a reset cycle can never consume a FIFO entry.
    assign w_pop        = (r_state == IDLE) && tx_en && !fifo_empty && !reset;
    assign w_wrap       = (r_baud == BAUD_LAST);
    assign fifo_read_en = w_pop;
    assign tx           = r_tx;
    assign busy         = (r_state != IDLE) || w_pop;
    assign byte_done    = r_byte_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_next = WAIT;
            WAIT:    w_next = START;
            START:   if (w_wrap) w_next = DATA;
            DATA:    if (w_wrap && (r_bit_idx == 3'd7)) w_next = STOP;
            STOP:    if (w_wrap) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_baud      <= '0;
            r_tx        <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                end
                WAIT: begin
                    r_shift   <= fifo_data_in;
                    r_bit_idx <= 3'd0;
                    r_baud    <= '0;
                    r_tx      <= 1'b0;
                end
                START: begin
                    r_baud <= w_wrap ? '0 : r_baud + 1'b1;
                    if (w_wrap) r_tx <= r_shift[0];
                end
                DATA: begin
                    r_baud <= w_wrap ? '0 : r_baud + 1'b1;
                    if (w_wrap) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        // Next level is the following data bit, or the stop bit after bit 7.
                        r_tx      <= (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
                    end
                end
                STOP: begin
                    r_baud <= w_wrap ? '0 : r_baud + 1'b1;
                    if (w_wrap) r_byte_done <= 1'b1;
                end
                default: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx at CLKS_PER_BIT 4 and 2
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int C = (g == 0) ? 4 : 2;
        logic       en;
        logic       empty;
        logic [7:0] dout;
        logic       rd;
        logic       txo;
        logic       bz;
        logic       bd;
        logic [7:0] mem [256];
        int         wr_cnt = 0;
        int         rd_cnt = 0;
        int         dones  = 0;
        int         frames = 0;
        int         last_start = -1;
        logic [7:0] expq [$];
        int         gaps [$];

        assign empty = (wr_cnt == rd_cnt);

        fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
            .clk          (clk),
            .reset        (reset),
            .tx_en        (en),
            .fifo_empty   (empty),
            .fifo_data_in (dout),
            .fifo_read_en (rd),
            .tx           (txo),
            .busy         (bz),
            .byte_done    (bd)
        );

        task automatic push(input logic [7:0] b);
            mem[wr_cnt % 256] = b;
            wr_cnt++;
            expq.push_back(b);
        endtask

        // FIFO model: a pop seen before an edge updates the output just after that edge.
        initial begin
            dout = 8'h00;
            forever begin
                @(negedge clk);
                if (reset) begin
                    check("rd_in_reset", int'(rd), 0);
                end else if (rd) begin
                    if (wr_cnt == rd_cnt) begin
                        check("pop_on_empty", 1, 0);
                    end else begin
                        @(posedge clk);
                        #1;
                        dout = mem[rd_cnt % 256];
                        rd_cnt++;
                    end
                end
            end
        end

        // Monitor: rebuilds each frame from the line and compares with write order.
        initial begin
            int pos;
            int cyc;
            int lvl;
            int exp_tx;
            logic [7:0] cur;
            logic [7:0] dummy;
            pos = -1;
            cyc = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (reset) begin
                    if (pos >= 0 && expq.size() > 0) dummy = expq.pop_front();
                    pos = -1;
                    continue;
                end
                if (bd) dones++;
                if (pos < 0 && txo == 1'b0) begin
                    if (expq.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        continue;
                    end
                    pos = 0;
                    if (last_start >= 0) gaps.push_back(cyc - last_start);
                    last_start = cyc;
                end
                if (pos < 0) begin
                    check("bd_idle", int'(bd), 0);
                end else if (pos < 10 * C) begin
                    lvl = pos / C;
                    cur = expq[0];
                    exp_tx = (lvl == 0) ? 0 : (lvl == 9) ? 1 : int'(cur[lvl-1]);
                    check("tx_level", int'(txo), exp_tx);
                    check("busy_frame", int'(bz), 1);
                    check("bd_frame", int'(bd), 0);
                    pos++;
                end else begin
                    check("bd_end", int'(bd), 1);
                    check("tx_end", int'(txo), 1);
                    check("busy_end", int'(bz), int'(rd));
                    dummy = expq.pop_front();
                    frames++;
                    pos = -1;
                end
            end
        end
    end

    task automatic wait_frames(input int g, input int target, input int lim);
        int n;
        n = 0;
        while (((g == 0) ? u[0].frames : u[1].frames) < target && n < lim) begin
            @(posedge clk);
            n++;
        end
        check("frame_timeout", (n < lim) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_fall0(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u[0].txo !== 1'b0 && n < lim);
        check("fall_timeout", int'(u[0].txo == 1'b0), 1);
    endtask

    initial begin
        int p;
        int bf;
        int bdn;
        int n;
        reset   = 1'b1;
        u[0].en = 1'b1;
        u[1].en = 1'b0;

        repeat (2) begin
            @(negedge clk);
            check("rst_tx", int'(u[0].txo), 1);
            check("rst_busy", int'(u[0].bz), 0);
            check("rst_rd", int'(u[0].rd), 0);
            check("rst_bd", int'(u[0].bd), 0);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_tx", int'(u[0].txo), 1);
            check("idle_busy", int'(u[0].bz), 0);
            check("idle_rd", int'(u[0].rd), 0);
        end

        // Single byte
        @(posedge clk);
        #2;
        p = u[0].rd_cnt; bf = u[0].frames; bdn = u[0].dones;
        u[0].push(8'hA5);
        wait_frames(0, bf + 1, 200);
        check("a5_pops", u[0].rd_cnt - p, 1);
        check("a5_dones", u[0].dones - bdn, 1);
        check("a5_empty", int'(u[0].empty), 1);

        // Back-to-back
        u[0].en = 1'b0;
        u[0].push(8'h00); u[0].push(8'hFF); u[0].push(8'h3C);
        p = u[0].rd_cnt; bf = u[0].frames; bdn = u[0].dones;
        @(posedge clk);
        #2;
        u[0].en = 1'b1;
        wait_frames(0, bf + 3, 400);
        check("b2b_pops", u[0].rd_cnt - p, 3);
        check("b2b_dones", u[0].dones - bdn, 3);
        check("b2b_empty", int'(u[0].empty), 1);
        n = u[0].gaps.size();
        check("b2b_gap1", (n >= 2) ? u[0].gaps[n-2] : -1, 42);
        check("b2b_gap2", (n >= 2) ? u[0].gaps[n-1] : -1, 42);

        // tx_en gating
        p = u[0].rd_cnt; bf = u[0].frames;
        u[0].push(8'h96); u[0].push(8'h81);
        wait_fall0(100);
        repeat (9) @(posedge clk);
        #2;
        u[0].en = 1'b0;
        wait_frames(0, bf + 1, 200);
        repeat (20) @(posedge clk);
        #2;
        check("gate_pops", u[0].rd_cnt - p, 1);
        check("gate_left", u[0].wr_cnt - u[0].rd_cnt, 1);
        u[0].en = 1'b1;
        wait_frames(0, bf + 2, 200);
        check("gate_empty", int'(u[0].empty), 1);

        // Reset during data bit 3
        bf = u[0].frames;
        u[0].push(8'h5A); u[0].push(8'hC3);
        wait_fall0(100);
        repeat (17) @(posedge clk);
        #2;
        p = u[0].rd_cnt; bdn = u[0].dones;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_tx", int'(u[0].txo), 1);
        check("mrst_busy", int'(u[0].bz), 0);
        check("mrst_bd", int'(u[0].bd), 0);
        #1;
        reset = 1'b0;
        check("mrst_no_pop", u[0].rd_cnt, p);
        wait_frames(0, bf + 1, 200);
        check("mrst_dones", u[0].dones - bdn, 1);
        check("mrst_empty", int'(u[0].empty), 1);

        // Random bytes with tx_en toggling
        bf = u[0].frames;
        for (int i = 0; i < 16; i++) begin
            u[0].push(8'($urandom));
            repeat ($urandom_range(0, 30)) begin
                @(posedge clk);
                #2;
                u[0].en = ($urandom_range(0, 3) != 0);
            end
        end
        u[0].en = 1'b1;
        wait_frames(0, bf + 16, 3000);
        check("rand_empty", int'(u[0].empty), 1);

        // Full FIFO at two clocks per bit
        for (int i = 0; i < 64; i++) u[1].push(8'($urandom));
        check("full_count", u[1].wr_cnt - u[1].rd_cnt, 64);
        u[1].en = 1'b1;
        wait_frames(1, 64, 2000);
        check("full_pops", u[1].rd_cnt, 64);
        check("full_dones", u[1].dones, 64);
        check("full_empty", int'(u[1].empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 64x8 synchronous FIFO. It pops one byte at a time through the FIFO's read port and shifts each byte out on a single serial line as an 8N1 UART frame at a fixed, parameterised bit period. It sits between the FIFO's read port and the chip-level serial pin, and drains the FIFO whenever transmission is enabled and data is present.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal range is 2..65535.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- tx_en  input  1  permits starting a new frame. It has no effect on a frame already in progress.
- fifo_empty  input  1  connects to FIFO buffer_empty.
- fifo_data_in  input  8  connects to FIFO buffer_out. It is valid on the cycle after the pop edge.
- fifo_read_en  output  1  connects to FIFO read_en. It is a one-cycle pop request.
- tx  output  1  serial line. It idles high.
- busy  output  1  is high from the pop cycle through the last stop-bit cycle.
- byte_done  output  1  is a one-cycle pulse when a stop bit completes.

## Operation
- The block is a state machine with states IDLE, WAIT, START, DATA and STOP.
- Internal registers:
  - 8-bit shift register.
  - 3-bit bit index.
  - Baud counter of width clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0.
- fifo_read_en is combinational and equals (state==IDLE) && tx_en && !fifo_empty && !reset. It is never high outside IDLE, so there is at most one pop per frame and no pop while the FIFO is empty.
- IDLE:
  - tx=1, busy is driven by fifo_read_en, baud counter held at 0.
  - If fifo_read_en=1, go to WAIT.
- WAIT (exactly 1 cycle):
  - The shift register latches fifo_data_in.
  - tx is registered to 0, bit index is set to 0.
  - Go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - On each baud wrap, shift right and increment the bit index.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - byte_done is registered high for the first IDLE cycle.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames, so consecutive frames are separated by exactly 2 extra high cycles on tx (the IDLE cycle and the WAIT cycle).
- tx_en falling mid-frame: the current frame completes normally, then the block stays in IDLE.
- fifo_empty rising mid-frame: ignored. The byte is already latched.
- Reset (including mid-frame):
  - At the reset edge: state=IDLE, tx=1, busy=0, byte_done=0, shift register=0, counters=0.
  - fifo_read_en=0 during reset, so no byte is lost from the FIFO.
  - A partial frame is truncated, with the line returning high.

## Timing
- Reset values: tx=1, busy=0, byte_done=0, fifo_read_en=0.
- Let edge E0 be the edge where fifo_read_en=1 is sampled. E0 is also where the FIFO updates buffer_out.
- E0+1: data is latched and tx falls.
- tx is low for edges E0+1 through E0+1+C, where C=CLKS_PER_BIT.
- Data bit i is driven from E0+1+C(1+i).
- The stop bit is driven from E0+1+9C.
- IDLE is entered at E0+1+10C, and byte_done is high for the one cycle following that edge.
- The frame is exactly 10C cycles of tx, from the falling start edge to the end of stop.
- Earliest next pop is in the first IDLE cycle, so the next start bit falls at E0+3+10C.
- busy is high from E0 (combinationally in the pop cycle) until the edge that enters IDLE.

## Test plan
- Reset then idle: hold reset 2 cycles, with FIFO empty and tx_en=1 -> tx=1, busy=0, fifo_read_en never asserted.
- Single byte 0xA5, C=4:
  - Stimulus: write 0xA5 into the FIFO, then tx_en=1.
  - Required: exactly one fifo_read_en pulse, tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles, one byte_done pulse 40 cycles after tx falls, FIFO empty afterwards.
- Back-to-back:
  - Stimulus: 3 bytes 0x00, 0xFF, 0x3C queued.
  - Required: three frames in order with a 2-cycle high gap between each, 3 read pulses, 3 byte_done pulses, fifo_empty=1 at the end.
- tx_en gating:
  - Stimulus: 2 bytes queued, tx_en dropped during the first frame's data bits.
  - Required: the first frame completes, no second pop, and the FIFO retains 1 byte.
  - Then raise tx_en -> second frame sent.
- Reset mid-frame: assert reset during data bit 3 -> next cycle tx=1, busy=0, no byte_done, and FIFO contents are unchanged by the reset cycle.
- Boundary: C=2 with the FIFO filled to 64 (buffer_full=1) -> all 64 bytes are emitted in write order with 64 byte_done pulses, the FIFO ends empty, and no pop is issued on empty.
